// File: rtl/route_filter_buffer.sv
// Per-packet hold buffer: beats wait in a small FIFO until the parser chain's
// route decision is final, then the whole packet is forwarded or discarded.
module route_filter_buffer #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int BUFFER_DEPTH    = 8,
  parameter int DROP_INCOMPLETE = 1,
  parameter int STAT_WIDTH      = 32,
  localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8,
  localparam int ID_W           = (AXIS_ID_WIDTH < 1) ? 1 : AXIS_ID_WIDTH,
  localparam int DEST_W         = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH,
  localparam int NUM_AXIS_ID    = 2 ** ID_W
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [ID_W-1:0]           axis_in_tid,
  input  logic [DEST_W-1:0]         axis_in_tdest,
  input  logic [NUM_BUS_BYTES-1:0]  axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [ID_W-1:0]           axis_out_tid,
  output logic [DEST_W-1:0]         axis_out_tdest,
  output logic [NUM_BUS_BYTES-1:0]  axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  input  logic [NUM_AXIS_ID-1:0]    route_mask_in,
  input  logic                      parsing_done_in,
  output logic [STAT_WIDTH-1:0]     pass_count,
  output logic [STAT_WIDTH-1:0]     drop_count,
  output logic [STAT_WIDTH-1:0]     overflow_count,
  output logic [1:0]                fsm_state
);

  // Handshake: a beat moves on either stream only in a cycle where valid and
  // ready are both high at the rising edge of aclk; valid never waits on ready.

  localparam int ADDR_W = $clog2(BUFFER_DEPTH);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  typedef struct packed {
    logic [AXIS_BUS_WIDTH-1:0] data;
    logic [NUM_BUS_BYTES-1:0]  keep;
    logic [ID_W-1:0]           id;
    logic [DEST_W-1:0]         dest;
    logic                      last;
  } beat_t;

  state_t state_q, state_d;
  beat_t  mem [BUFFER_DEPTH];
  beat_t  head;

  logic [ADDR_W:0]     wr_ptr_q, rd_ptr_q;
  logic                fifo_empty, fifo_full;
  logic                in_done_q;
  logic                in_ready, out_valid;
  logic                in_acc, deciding, pass_hit, incomplete;
  logic                push, pop, clr_done;
  logic                inc_pass, inc_drop, inc_ovf;
  logic [STAT_WIDTH-1:0] pass_q, drop_q, ovf_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q == {~rd_ptr_q[ADDR_W], rd_ptr_q[ADDR_W-1:0]});
  assign head       = mem[rd_ptr_q[ADDR_W-1:0]];

  // Ready depends only on registered state (and out_tready when a pop frees a slot).
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_COLLECT: in_ready = !fifo_full && !in_done_q;
      ST_FORWARD: in_ready = (!fifo_full || axis_out_tready) && !in_done_q;
      ST_DROP:    in_ready = !in_done_q;
      default:    in_ready = 1'b0;
    endcase
  end

  assign axis_in_tready = aresetn && in_ready;
  assign in_acc         = axis_in_tvalid && axis_in_tready;
  assign pass_hit       = route_mask_in[axis_in_tid];
  assign deciding       = in_acc && (parsing_done_in || axis_in_tlast);
  assign incomplete     = axis_in_tlast && !parsing_done_in;

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clr_done  = 1'b0;
    inc_pass  = 1'b0;
    inc_drop  = 1'b0;
    inc_ovf   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        push = in_acc;
        if (deciding) begin
          if ((incomplete && (DROP_INCOMPLETE != 0)) || !pass_hit) begin
            state_d  = ST_DROP;
            inc_drop = 1'b1;
          end else begin
            state_d = ST_FORWARD;
          end
        end else if (fifo_full) begin
          // Buffer exhausted before the parser chain committed.
          state_d  = ST_DROP;
          inc_drop = 1'b1;
          inc_ovf  = 1'b1;
        end
      end
      ST_FORWARD: begin
        out_valid = aresetn && !fifo_empty;
        pop       = out_valid && axis_out_tready;
        push      = in_acc;
        if (pop && head.last) begin
          state_d  = ST_COLLECT;
          clr_done = 1'b1;
          inc_pass = 1'b1;
        end
      end
      ST_DROP: begin
        pop = !fifo_empty;
        if (in_done_q && fifo_empty) begin
          state_d  = ST_COLLECT;
          clr_done = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_COLLECT;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      in_done_q <= 1'b0;
      pass_q    <= '0;
      drop_q    <= '0;
      ovf_q     <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
      if (clr_done) in_done_q <= 1'b0;
      else if (in_acc && axis_in_tlast) in_done_q <= 1'b1;
      if (inc_pass) pass_q <= pass_q + STAT_WIDTH'(1);
      if (inc_drop) drop_q <= drop_q + STAT_WIDTH'(1);
      if (inc_ovf)  ovf_q  <= ovf_q + STAT_WIDTH'(1);
    end
  end

  // Storage is not reset: empty pointers already mask stale contents.
  always_ff @(posedge aclk) begin
    if (aresetn && push) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= '{data: axis_in_tdata, keep: axis_in_tkeep,
                                     id: axis_in_tid, dest: axis_in_tdest,
                                     last: axis_in_tlast};
    end
  end

  assign axis_out_tvalid = out_valid;
  assign axis_out_tdata  = head.data;
  assign axis_out_tkeep  = head.keep;
  assign axis_out_tid    = head.id;
  assign axis_out_tdest  = head.dest;
  assign axis_out_tlast  = head.last;
  assign pass_count      = pass_q;
  assign drop_count      = drop_q;
  assign overflow_count  = ovf_q;
  assign fsm_state       = state_q;

endmodule

// File: tb/tb_route_filter_buffer.sv
// Directed bench for route_filter_buffer: pass, filter, overflow, back-pressure,
// incomplete-packet policy and mid-packet reset.
module tb_route_filter_buffer;

  localparam int W   = 64;
  localparam int IDW = 4;
  localparam int DW  = 4;
  localparam int KW  = 8;
  localparam int NID = 16;
  localparam int SW  = 32;
  localparam int PW  = 1 + KW + DW + IDW + W;

  // clock / reset
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [W-1:0]   axis_in_tdata  = '0;
  logic [IDW-1:0] axis_in_tid    = '0;
  logic [DW-1:0]  axis_in_tdest  = '0;
  logic [KW-1:0]  axis_in_tkeep  = '0;
  logic           axis_in_tlast  = 1'b0;
  logic           axis_in_tvalid = 1'b0;
  logic           axis_in_tready;
  logic [NID-1:0] route_mask_in  = '0;
  logic           parsing_done_in = 1'b0;
  logic [W-1:0]   axis_out_tdata;
  logic [IDW-1:0] axis_out_tid;
  logic [DW-1:0]  axis_out_tdest;
  logic [KW-1:0]  axis_out_tkeep;
  logic           axis_out_tlast;
  logic           axis_out_tvalid;
  logic           axis_out_tready = 1'b1;
  logic [SW-1:0]  pass_count, drop_count, overflow_count;
  logic [1:0]     fsm_state;

  // second instance with the incomplete-packet policy relaxed
  logic           b_en = 1'b0;
  logic           b_in_tvalid, b_in_tready;
  logic [W-1:0]   b_out_tdata;
  logic [IDW-1:0] b_out_tid;
  logic [DW-1:0]  b_out_tdest;
  logic [KW-1:0]  b_out_tkeep;
  logic           b_out_tlast, b_out_tvalid, b_out_tready;
  logic [SW-1:0]  b_pass_count, b_drop_count, b_overflow_count;
  logic [1:0]     b_fsm_state;
  assign b_in_tvalid  = axis_in_tvalid && b_en;
  assign b_out_tready = 1'b1;

  route_filter_buffer #(.DROP_INCOMPLETE(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(axis_in_tdata), .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .route_mask_in(route_mask_in), .parsing_done_in(parsing_done_in),
    .pass_count(pass_count), .drop_count(drop_count), .overflow_count(overflow_count),
    .fsm_state(fsm_state)
  );

  route_filter_buffer #(.DROP_INCOMPLETE(0)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(axis_in_tdata), .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_in_tvalid(b_in_tvalid), .axis_in_tready(b_in_tready),
    .axis_out_tdata(b_out_tdata), .axis_out_tid(b_out_tid), .axis_out_tdest(b_out_tdest),
    .axis_out_tkeep(b_out_tkeep), .axis_out_tlast(b_out_tlast),
    .axis_out_tvalid(b_out_tvalid), .axis_out_tready(b_out_tready),
    .route_mask_in(route_mask_in), .parsing_done_in(parsing_done_in),
    .pass_count(b_pass_count), .drop_count(b_drop_count), .overflow_count(b_overflow_count),
    .fsm_state(b_fsm_state)
  );

  // scoreboard
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] b_exp_q[$];
  logic [PW-1:0] b_got_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int tlast_out_cnt = 0;
  bit gate_armed = 1'b0;
  int gate_base  = 0;
  int tready_mode = 0;  // 0: always ready, 1: toggle, 2: held low

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PW-1:0] pack(input logic [W-1:0] d, input logic [KW-1:0] k,
                                         input logic [DW-1:0] de, input logic [IDW-1:0] id,
                                         input logic l);
    return {l, k, de, id, d};
  endfunction

  always @(negedge aclk) begin
    case (tready_mode)
      1:       axis_out_tready = ~axis_out_tready;
      2:       axis_out_tready = 1'b0;
      default: axis_out_tready = 1'b1;
    endcase
  end

  // output monitors sample just after the falling edge, ahead of the next rising edge
  always @(negedge aclk) begin
    #1;
    if (axis_out_tvalid && axis_out_tready) begin
      got_q.push_back(pack(axis_out_tdata, axis_out_tkeep, axis_out_tdest, axis_out_tid, axis_out_tlast));
      if (axis_out_tlast) tlast_out_cnt++;
    end
    if (b_out_tvalid && b_out_tready)
      b_got_q.push_back(pack(b_out_tdata, b_out_tkeep, b_out_tdest, b_out_tid, b_out_tlast));
  end

  // driver tasks
  task automatic send_beat(input logic [W-1:0] d, input logic [IDW-1:0] id, input logic [DW-1:0] de,
                           input logic [KW-1:0] k, input logic l, input logic [NID-1:0] mask,
                           input logic pd, output bit ok);
    int guard = 0;
    @(negedge aclk);
    axis_in_tdata = d; axis_in_tid = id; axis_in_tdest = de; axis_in_tkeep = k;
    axis_in_tlast = l; route_mask_in = mask; parsing_done_in = pd; axis_in_tvalid = 1'b1;
    #2;
    while (!axis_in_tready && guard < 100) begin
      @(negedge aclk); #2; guard++;
    end
    ok = axis_in_tready;
    if (ok) @(posedge aclk);
    #1 axis_in_tvalid = 1'b0;
    if (!ok) check("in_tready_timeout", 0, 1);
    if (ok && gate_armed) begin
      check("second_pkt_gated", (tlast_out_cnt > gate_base), 1);
      gate_armed = 1'b0;
    end
  endtask

  task automatic send_pkt(input int n, input logic [W-1:0] base, input logic [IDW-1:0] id,
                          input logic [NID-1:0] mask, input int pd_beat, input bit with_last,
                          input bit fwd, output int acc);
    bit ok;
    logic [KW-1:0] k;
    logic l;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      k = (i == n - 1) ? 8'h3F : 8'hFF;
      l = with_last && (i == n - 1);
      send_beat(base + W'(i), id, id ^ 4'h5, k, l, mask, (i == pd_beat), ok);
      if (ok) acc++;
      if (ok && fwd) exp_q.push_back(pack(base + W'(i), k, id ^ 4'h5, id, l));
    end
  endtask

  task automatic expect_drain(input string tag);
    int guard = 0;
    while (got_q.size() < exp_q.size() && guard < 300) begin
      @(negedge aclk); guard++;
    end
    repeat (4) @(negedge aclk);
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_beat"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    @(negedge aclk); #2;
    while (!(fsm_state == 2'd0 && axis_in_tready) && guard < 100) begin
      @(negedge aclk); #2; guard++;
    end
    check(tag, (fsm_state == 2'd0 && axis_in_tready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int acc;

    // reset state
    repeat (3) @(negedge aclk);
    #1;
    check("rst_in_tready", axis_in_tready, 0);
    check("rst_out_tvalid", axis_out_tvalid, 0);
    aresetn = 1'b1;
    @(negedge aclk); #2;
    check("rst_counts", {pass_count, drop_count, overflow_count}, 0);
    check("rst_state", fsm_state, 0);
    check("rst_ready_after", axis_in_tready, 1);

    // 3-beat packet, tid 2, mask bit 2, parsing done on beat index 1
    send_pkt(3, 64'hA000_0000_0000_0100, 4'd2, 16'h0004, 1, 1'b1, 1'b1, acc);
    expect_drain("pass3");
    check("pass3_pass_count", pass_count, 1);
    check("pass3_drop_count", drop_count, 0);

    // same packet with an empty mask
    send_pkt(3, 64'hA000_0000_0000_0100, 4'd2, 16'h0000, 1, 1'b1, 1'b0, acc);
    wait_idle("drop3_ready_back");
    expect_drain("drop3");
    check("drop3_drop_count", drop_count, 1);
    check("drop3_pass_count", pass_count, 1);

    // 12-beat packet, no decision before the buffer fills
    send_pkt(12, 64'hB000_0000_0000_0000, 4'd7, 16'hFFFF, -1, 1'b1, 1'b0, acc);
    check("ovf_accepted", acc, 12);
    wait_idle("ovf_idle");
    expect_drain("ovf");
    check("ovf_overflow_count", overflow_count, 1);
    check("ovf_drop_count", drop_count, 2);

    // back-pressure toggling, second packet must wait for the first tlast out
    tready_mode = 1;
    send_pkt(5, 64'hC000_0000_0000_0010, 4'd5, 16'h0020, 0, 1'b1, 1'b1, acc);
    gate_base  = tlast_out_cnt;
    gate_armed = 1'b1;
    send_pkt(2, 64'hC100_0000_0000_0020, 4'd1, 16'h0002, 1, 1'b1, 1'b1, acc);
    expect_drain("toggle");
    tready_mode = 0;
    check("toggle_pass_count", pass_count, 3);

    // incomplete packet: dropped with policy on, forwarded with it off
    wait_idle("inc_idle");
    check("inc_b_ready", b_in_tready, 1);
    b_en = 1'b1;
    send_pkt(2, 64'hD000_0000_0000_0030, 4'd9, 16'hFFFF, -1, 1'b1, 1'b1, acc);
    b_en = 1'b0;
    b_exp_q = exp_q;
    exp_q.delete();
    wait_idle("inc_drop_idle");
    expect_drain("inc_drop");
    check("inc_drop_count", drop_count, 3);
    check("inc_b_beats", b_got_q.size(), 2);
    while (b_exp_q.size() > 0 && b_got_q.size() > 0)
      check("inc_b_beat", b_got_q.pop_front(), b_exp_q.pop_front());
    check("inc_b_pass_count", b_pass_count, 1);

    // reset while forwarding with the output stalled
    tready_mode = 2;
    send_pkt(3, 64'hE000_0000_0000_0040, 4'd3, 16'h0008, 0, 1'b0, 1'b0, acc);
    @(negedge aclk); #2;
    check("mid_valid_before_rst", axis_out_tvalid, 1);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #2;
    check("mid_valid_after_rst", axis_out_tvalid, 0);
    check("mid_counts_cleared", {pass_count, drop_count, overflow_count}, 0);
    check("mid_state", fsm_state, 0);
    got_q.delete();
    tready_mode = 0;
    send_pkt(2, 64'hF000_0000_0000_0050, 4'd4, 16'h0010, 1, 1'b1, 1'b1, acc);
    expect_drain("post_rst");
    check("post_rst_pass_count", pass_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/route_filter_buffer.md
Name: route_filter_buffer

Overview:
- Stage directly downstream of the port CAM parser.
- Holds each packet in a small FIFO until the parser chain's routing decision is final.
- Then forwards the whole packet, or silently discards it.
- Sits at the end of the NMU parse/filter pipeline, before the per-ID output demux.

Parameters:
- AXIS_BUS_WIDTH, 64, data width in bits; NUM_BUS_BYTES = AXIS_BUS_WIDTH/8.
- AXIS_ID_WIDTH, 4, tid width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH; effective width is at least 1.
- AXIS_DEST_WIDTH, 4, tdest width; effective width is at least 1.
- BUFFER_DEPTH, 8, FIFO depth in beats; must be a power of 2 and ≥ 2.
- DROP_INCOMPLETE, 1. 1: a packet ending with parsing_done never seen is dropped. 0: it is decided on the mask at its last beat.
- STAT_WIDTH, 32, width of the statistics counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- axis_in_tdata/tid/tdest/tkeep/tlast  in  bus widths  input stream payload
- axis_in_tvalid  in  1  input valid
- axis_in_tready  out  1  input ready
- axis_out_tdata/tid/tdest/tkeep/tlast  out  bus widths  output stream payload
- axis_out_tvalid  out  1  output valid
- axis_out_tready  in  1  output ready
- route_mask_in  in  NUM_AXIS_ID  upstream route mask, valid with the current input beat
- parsing_done_in  in  1  upstream parsing complete, valid with the current input beat
- pass_count  out  STAT_WIDTH  packets forwarded
- drop_count  out  STAT_WIDTH  packets dropped (filtered or overflow)
- overflow_count  out  STAT_WIDTH  packets dropped because the buffer filled before a decision

Behaviour:
- Reset: aresetn, synchronous, active-low; clock aclk.
  - FIFO empty; state COLLECT; in_done = 0; all counters 0.
  - axis_out_tvalid = 0; axis_in_tready = 0 during reset.
- Accepted input beat: axis_in_tvalid & axis_in_tready. route_mask_in and parsing_done_in are sampled only on accepted beats.
- Pass test: route_mask_in[axis_in_tid] == 1 on the deciding beat.
- State COLLECT (no decision yet):
  - axis_in_tready = !fifo_full & !in_done; accepted beats are pushed; axis_out_tvalid = 0.
  - Deciding beat = first accepted beat with parsing_done_in = 1, or the tlast beat if none earlier. That beat is still pushed.
  - tlast beat without parsing_done_in and DROP_INCOMPLETE = 1 → DROP.
  - Otherwise pass test true → FORWARD, false → DROP.
  - FIFO full with no decision → DROP; overflow_count and drop_count each +1 at that transition.
  - The transition takes effect on the cycle after the deciding beat.
- State FORWARD:
  - axis_out_* driven from the FIFO head; axis_out_tvalid = !fifo_empty.
  - Input keeps filling while !fifo_full & !in_done.
  - Push and pop in the same cycle are allowed, including when full.
  - Popping the beat with tlast = 1 → COLLECT, clear in_done, pass_count +1.
- State DROP:
  - axis_out_tvalid = 0. FIFO pops one beat per cycle with no output handshake.
  - axis_in_tready = !in_done; dropped input beats are not pushed.
  - Exit when in_done = 1 and FIFO empty → COLLECT, clear in_done.
  - drop_count +1 on entry (overflow entry counts once only).
- in_done: set when an input tlast beat is accepted, whether pushed or discarded. While set, axis_in_tready = 0. This guarantees one packet in flight.
- Simultaneous events: a tlast input beat that also decides, with a full FIFO, is decided normally and is not counted as overflow.
- Single-beat packets are decided on their only beat.
- Latency: first output beat is valid no earlier than 1 cycle after the deciding beat. Throughput in FORWARD is 1 beat/cycle.
- Counters wrap at 2**STAT_WIDTH.
- Output payload is the registered FIFO contents, bit-exact; tkeep/tid/tdest are unmodified.
- Reset mid-packet: all state discarded. No partial output beats after reset; counters are cleared.

Test Plan:
- 3-beat packet, tid=2, route_mask=0x0004, parsing_done on beat 2 → exactly 3 beats out, identical data, tlast on beat 3; pass_count=1.
- Same packet with route_mask=0x0000 → no output; drop_count=1; axis_in_tready returns high once the FIFO is empty.
- BUFFER_DEPTH=8, 12-beat packet, parsing_done never asserted before beat 9 → overflow_count=1, drop_count=1; all 12 input beats accepted; nothing out.
- Forwarding packet with axis_out_tready toggling 1/0 each cycle → order preserved; no beat lost or duplicated; second packet not accepted before the first tlast is accepted.
- DROP_INCOMPLETE=1, 2-beat packet with parsing_done=0 and mask all ones → dropped; with DROP_INCOMPLETE=0 → forwarded.
- Assert aresetn=0 for 1 cycle mid-forward → axis_out_tvalid=0 the next cycle; counters=0; the next packet is handled normally.
